// File: rtl/lc3b_pkg.sv
// LC-3b shared definitions: control-word bit indices, mux encodings, MEM FSM states.
// The ERR state exists only when MEM_STAGE_WATCHDOG_EN is defined.
package lc3b_pkg;

    localparam int CS_DCACHE_EN = 9;
    localparam int CS_DCACHE_RW = 8;
    localparam int CS_DATA_SIZE = 7;
    localparam int CS_BR_OP     = 6;
    localparam int CS_UNCOND_OP = 5;
    localparam int CS_TRAP_OP   = 4;

    localparam logic [1:0] PCMUX_NEXT   = 2'b00;
    localparam logic [1:0] PCMUX_TARGET = 2'b01;
    localparam logic [1:0] PCMUX_TRAP   = 2'b10;

    localparam logic [1:0] VMUX_ALU  = 2'b00;
    localparam logic [1:0] VMUX_MEM  = 2'b01;
    localparam logic [1:0] VMUX_NPC  = 2'b10;
    localparam logic [1:0] VMUX_ADDR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT
`ifdef MEM_STAGE_WATCHDOG_EN
        ,
        ST_ERR
`endif
    } mem_state_t;

endpackage

// File: rtl/mem_data_align.sv
// Byte/word lane steering for the data cache: write lanes and enables,
// read byte selection with sign extension. Purely combinational.
module mem_data_align (
    input  logic        word,
    input  logic        wr,
    input  logic        byte_sel,
    input  logic [15:0] wr_src,
    input  logic [15:0] rdata,
    output logic [1:0]  we,
    output logic [15:0] wdata,
    output logic [15:0] rd
);

    logic [7:0] rbyte;

    assign rbyte = byte_sel ? rdata[15:8] : rdata[7:0];
    assign rd    = word ? rdata : {{8{rbyte[7]}}, rbyte};
    assign wdata = word ? wr_src : {2{wr_src[7:0]}};

    always_comb begin
        we = 2'b00;
        if (wr) begin
            if (word)
                we = 2'b11;
            else
                we = byte_sel ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: data-cache access, control-flow resolution, SR latches.
// Optional watchdog / stall counter enabled by MEM_STAGE_WATCHDOG_EN.
module mem_stage
    import lc3b_pkg::*;
#(
    parameter int DCACHE_MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_v,
    input  logic [15:0] mem_ir,
    input  logic [15:0] mem_npc,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_alu_result,
    input  logic [2:0]  mem_drid,
    input  logic [2:0]  mem_cc,
    input  logic [9:0]  mem_cs,
    output logic        dcache_req,
    output logic [1:0]  dcache_we,
    output logic [14:0] dcache_addr,
    output logic [15:0] dcache_wdata,
    input  logic [15:0] dcache_rdata,
    input  logic        dcache_r,
    output logic        mem_stall,
    output logic        v_mem_br_stall,
    output logic [1:0]  mem_pcmux,
    output logic [15:0] target_pc,
    output logic [15:0] trap_pc,
    output logic        sr_v,
    output logic [15:0] sr_ir,
    output logic [15:0] sr_npc,
    output logic [15:0] sr_address,
    output logic [15:0] sr_alu_result,
    output logic [15:0] sr_data,
    output logic [2:0]  sr_drid,
    output logic [3:0]  sr_cs
`ifdef MEM_STAGE_WATCHDOG_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    mem_state_t  state;
    logic        acc;
    logic        err;
    logic        br;
    logic        uncond;
    logic        trap;
    logic        taken;
    logic [15:0] rd;

    assign acc = mem_v & mem_cs[CS_DCACHE_EN];

`ifdef MEM_STAGE_WATCHDOG_EN
    localparam logic [3:0] MAX_W = 4'(DCACHE_MAX_WAIT - 1);
    logic [3:0] wait_cnt;
    assign err = (state == ST_ERR);
`else
    logic [31:0] unused_max_wait;
    assign unused_max_wait = DCACHE_MAX_WAIT;
    assign err = 1'b0;
`endif

    assign dcache_req  = acc & ~err;
    assign dcache_addr = mem_address[15:1];
    assign mem_stall   = (acc & ~dcache_r) | err;

    mem_data_align u_align (
        .word     (mem_cs[CS_DATA_SIZE]),
        .wr       (acc & mem_cs[CS_DCACHE_RW]),
        .byte_sel (mem_address[0]),
        .wr_src   (mem_alu_result),
        .rdata    (dcache_rdata),
        .we       (dcache_we),
        .wdata    (dcache_wdata),
        .rd       (rd)
    );

    assign br     = mem_cs[CS_BR_OP];
    assign uncond = mem_cs[CS_UNCOND_OP];
    assign trap   = mem_cs[CS_TRAP_OP];
    assign taken  = br & |(mem_ir[11:9] & mem_cc);

    assign v_mem_br_stall = mem_v & (br | uncond | trap);
    assign target_pc      = mem_address;
    assign trap_pc        = dcache_rdata;

    // A stalled TRAP has no vector yet, so fetch keeps its PC.
    always_comb begin
        mem_pcmux = PCMUX_NEXT;
        if (!mem_stall) begin
            if (mem_v & trap & dcache_r)
                mem_pcmux = PCMUX_TRAP;
            else if (mem_v & (uncond | taken))
                mem_pcmux = PCMUX_TARGET;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
`ifdef MEM_STAGE_WATCHDOG_EN
            wait_cnt <= 4'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc & ~dcache_r) begin
                        state <= ST_WAIT;
`ifdef MEM_STAGE_WATCHDOG_EN
                        wait_cnt <= 4'd1;
`endif
                    end
                end
                ST_WAIT: begin
                    if (dcache_r) begin
                        state <= ST_IDLE;
`ifdef MEM_STAGE_WATCHDOG_EN
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt == MAX_W) begin
                        state <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
`endif
                    end
                end
`ifdef MEM_STAGE_WATCHDOG_EN
                ST_ERR: state <= ST_ERR;
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_v          <= 1'b0;
            sr_ir         <= 16'h0;
            sr_npc        <= 16'h0;
            sr_address    <= 16'h0;
            sr_alu_result <= 16'h0;
            sr_data       <= 16'h0;
            sr_drid       <= 3'h0;
            sr_cs         <= 4'h0;
        end else if (mem_stall) begin
            sr_v <= 1'b0;
        end else begin
            sr_v          <= mem_v;
            sr_ir         <= mem_ir;
            sr_npc        <= mem_npc;
            sr_address    <= mem_address;
            sr_alu_result <= mem_alu_result;
            sr_data       <= acc ? rd : 16'h0;
            sr_drid       <= mem_drid;
            sr_cs         <= mem_cs[3:0];
        end
    end

`ifdef MEM_STAGE_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 16'h0;
        else if (mem_stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'h1;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage.
// Watchdog vectors are compiled in when MEM_STAGE_WATCHDOG_EN is defined.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_v;
    logic [15:0] mem_ir;
    logic [15:0] mem_npc;
    logic [15:0] mem_address;
    logic [15:0] mem_alu_result;
    logic [2:0]  mem_drid;
    logic [2:0]  mem_cc;
    logic [9:0]  mem_cs;
    logic        dcache_req;
    logic [1:0]  dcache_we;
    logic [14:0] dcache_addr;
    logic [15:0] dcache_wdata;
    logic [15:0] dcache_rdata;
    logic        dcache_r;
    logic        mem_stall;
    logic        v_mem_br_stall;
    logic [1:0]  mem_pcmux;
    logic [15:0] target_pc;
    logic [15:0] trap_pc;
    logic        sr_v;
    logic [15:0] sr_ir;
    logic [15:0] sr_npc;
    logic [15:0] sr_address;
    logic [15:0] sr_alu_result;
    logic [15:0] sr_data;
    logic [2:0]  sr_drid;
    logic [3:0]  sr_cs;
`ifdef MEM_STAGE_WATCHDOG_EN
    logic [15:0] stall_cnt;
`endif

    int n_vec;
    int n_bad;

    mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_v          (mem_v),
        .mem_ir         (mem_ir),
        .mem_npc        (mem_npc),
        .mem_address    (mem_address),
        .mem_alu_result (mem_alu_result),
        .mem_drid       (mem_drid),
        .mem_cc         (mem_cc),
        .mem_cs         (mem_cs),
        .dcache_req     (dcache_req),
        .dcache_we      (dcache_we),
        .dcache_addr    (dcache_addr),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_r       (dcache_r),
        .mem_stall      (mem_stall),
        .v_mem_br_stall (v_mem_br_stall),
        .mem_pcmux      (mem_pcmux),
        .target_pc      (target_pc),
        .trap_pc        (trap_pc),
        .sr_v           (sr_v),
        .sr_ir          (sr_ir),
        .sr_npc         (sr_npc),
        .sr_address     (sr_address),
        .sr_alu_result  (sr_alu_result),
        .sr_data        (sr_data),
        .sr_drid        (sr_drid),
        .sr_cs          (sr_cs)
`ifdef MEM_STAGE_WATCHDOG_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs change only after this.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] cs,
                         input logic [15:0] ir, input logic [15:0] addr,
                         input logic [15:0] alu, input logic [2:0] cc,
                         input logic r, input logic [15:0] rdata);
        mem_v          = v;
        mem_cs         = cs;
        mem_ir         = ir;
        mem_address    = addr;
        mem_alu_result = alu;
        mem_cc         = cc;
        dcache_r       = r;
        dcache_rdata   = rdata;
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        mem_npc = 16'h0102;
        mem_drid = 3'd5;
        drive(1'b0, 10'h000, 16'h0, 16'h0, 16'h0, 3'b000, 1'b0, 16'h0);
        #12;
        chk("rst_sr_v", {15'h0, sr_v}, 16'h0);
        chk("rst_sr_data", sr_data, 16'h0);
        chk("rst_sr_ir", sr_ir, 16'h0);
        chk("rst_sr_cs", {12'h0, sr_cs}, 16'h0);
        rst_n = 1'b1;
        tick();

        // LDW, zero-wait
        drive(1'b1, 10'h286, 16'h6200, 16'h3000, 16'h0, 3'b000,
              1'b1, 16'h8001);
        chk("ldw_req", {15'h0, dcache_req}, 16'h1);
        chk("ldw_stall", {15'h0, mem_stall}, 16'h0);
        chk("ldw_we", {14'h0, dcache_we}, 16'h0);
        chk("ldw_addr", {1'b0, dcache_addr}, 16'h1800);
        tick();
        chk("ldw_sr_v", {15'h0, sr_v}, 16'h1);
        chk("ldw_sr_data", sr_data, 16'h8001);
        chk("ldw_sr_cs", {12'h0, sr_cs}, 16'h6);
        chk("ldw_sr_addr", sr_address, 16'h3000);
        chk("ldw_sr_drid", {13'h0, sr_drid}, 16'h5);

        // LDB, odd byte, two wait cycles
        drive(1'b1, 10'h206, 16'h2200, 16'h3001, 16'h0, 3'b000,
              1'b0, 16'h80FF);
        for (int i = 0; i < 2; i++) begin
            chk("ldb_stall", {15'h0, mem_stall}, 16'h1);
            chk("ldb_pcmux", {14'h0, mem_pcmux}, 16'h0);
            tick();
            chk("ldb_bubble", {15'h0, sr_v}, 16'h0);
            chk("ldb_hold", sr_data, 16'h8001);
        end
        dcache_r = 1'b1;
        #1;
        chk("ldb_done_stall", {15'h0, mem_stall}, 16'h0);
        tick();
        chk("ldb_sr_v", {15'h0, sr_v}, 16'h1);
        chk("ldb_sr_data", sr_data, 16'hFF80);

        // STB even / odd, STW
        drive(1'b1, 10'h300, 16'h3000, 16'h4000, 16'h12AB, 3'b000,
              1'b1, 16'h0);
        chk("stb0_we", {14'h0, dcache_we}, 16'h1);
        chk("stb0_wdata", dcache_wdata, 16'hABAB);
        drive(1'b1, 10'h300, 16'h3000, 16'h4001, 16'h12AB, 3'b000,
              1'b1, 16'h0);
        chk("stb1_we", {14'h0, dcache_we}, 16'h2);
        chk("stb1_wdata", dcache_wdata, 16'hABAB);
        drive(1'b1, 10'h380, 16'h7000, 16'h4002, 16'h12AB, 3'b000,
              1'b1, 16'h0);
        chk("stw_we", {14'h0, dcache_we}, 16'h3);
        chk("stw_wdata", dcache_wdata, 16'h12AB);
        tick();

        // BRz taken / not taken
        drive(1'b1, 10'h040, 16'h0410, 16'h2040, 16'h0, 3'b010,
              1'b0, 16'h0);
        chk("brz_t_pcmux", {14'h0, mem_pcmux}, 16'h1);
        chk("brz_t_target", target_pc, 16'h2040);
        chk("brz_brstall", {15'h0, v_mem_br_stall}, 16'h1);
        chk("brz_req", {15'h0, dcache_req}, 16'h0);
        chk("brz_stall", {15'h0, mem_stall}, 16'h0);
        drive(1'b1, 10'h040, 16'h0410, 16'h2040, 16'h0, 3'b100,
              1'b0, 16'h0);
        chk("brz_nt_pcmux", {14'h0, mem_pcmux}, 16'h0);
        tick();
        chk("br_sr_v", {15'h0, sr_v}, 16'h1);
        chk("br_sr_data", sr_data, 16'h0);
        chk("br_sr_ir", sr_ir, 16'h0410);

        // JMP
        drive(1'b1, 10'h020, 16'hC080, 16'h5555, 16'h0, 3'b000,
              1'b0, 16'h0);
        chk("jmp_pcmux", {14'h0, mem_pcmux}, 16'h1);
        drive(1'b0, 10'h020, 16'hC080, 16'h5555, 16'h0, 3'b000,
              1'b1, 16'h0);
        chk("inv_pcmux", {14'h0, mem_pcmux}, 16'h0);
        chk("inv_req", {15'h0, dcache_req}, 16'h0);
        chk("inv_stall", {15'h0, mem_stall}, 16'h0);
        tick();
        chk("inv_sr_v", {15'h0, sr_v}, 16'h0);

        // TRAP with one wait cycle
        drive(1'b1, 10'h290, 16'hF025, 16'h004A, 16'h0, 3'b000,
              1'b0, 16'h1200);
        chk("trap_wait_pcmux", {14'h0, mem_pcmux}, 16'h0);
        chk("trap_wait_stall", {15'h0, mem_stall}, 16'h1);
        tick();
        dcache_r = 1'b1;
        #1;
        chk("trap_pcmux", {14'h0, mem_pcmux}, 16'h2);
        chk("trap_pc", trap_pc, 16'h1200);
        tick();
        chk("trap_sr_data", sr_data, 16'h1200);

        // Reset during WAIT
        drive(1'b1, 10'h286, 16'h6200, 16'h3000, 16'h0, 3'b000,
              1'b0, 16'h0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_sr_data", sr_data, 16'h0);
        chk("rstw_sr_ir", sr_ir, 16'h0);
        mem_v = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        chk("rstw_req", {15'h0, dcache_req}, 16'h0);
        tick();

`ifdef MEM_STAGE_WATCHDOG_EN
        rst_n = 1'b0;
        #1;
        chk("wd_cnt_rst", stall_cnt, 16'h0);
        rst_n = 1'b1;
        drive(1'b1, 10'h286, 16'h6200, 16'h3000, 16'h0, 3'b000,
              1'b0, 16'h0);
        for (int i = 0; i < 14; i++) tick();
        chk("wd_req_pre", {15'h0, dcache_req}, 16'h1);
        tick();
        chk("wd_req_err", {15'h0, dcache_req}, 16'h0);
        chk("wd_stall_err", {15'h0, mem_stall}, 16'h1);
        chk("wd_cnt15", stall_cnt, 16'd15);
        mem_v = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("wd_stall_hold", {15'h0, mem_stall}, 16'h1);
        chk("wd_cnt18", stall_cnt, 16'd18);
        rst_n = 1'b0;
        #1;
        chk("wd_cnt_clr", stall_cnt, 16'h0);
        chk("wd_stall_clr", {15'h0, mem_stall}, 16'h0);
        rst_n = 1'b1;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
